// File: rtl/dmem_copy_engine.sv
// Block-copy bus master for the LEGv8 data memory: moves len doublewords from
// src_addr to dst_addr in ascending order, one READ/WRITE cycle pair per word.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// READ  | MemRead at src_ptr, capture r_data into data_buf
// WRITE | MemWrite of data_buf at dst_ptr, count down remaining
// DONE  | one-cycle completion pulse
// ERR   | one-cycle reject pulse for a misaligned request
module dmem_copy_engine #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      src_addr,
  input  logic [63:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [63:0]      addr,
  output logic [63:0]      w_data,
  input  logic [63:0]      r_data
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  state_t           state, state_nxt;
  logic [63:0]      src_ptr, dst_ptr, data_buf;
  logic [LEN_W-1:0] remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      data_buf  <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          src_ptr   <= src_addr;
          dst_ptr   <= dst_addr;
          remaining <= len;
        end
        READ: begin
          data_buf <= r_data;
          src_ptr  <= src_ptr + 64'd8;
        end
        WRITE: begin
          dst_ptr   <= dst_ptr + 64'd8;
          remaining <= remaining - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the registered state and pointers only, so addr/w_data
  // are stable across the whole strobe cycle.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    addr      = '0;
    w_data    = '0;
    case (state)
      IDLE: if (start) begin
        if ((src_addr[2:0] != 3'd0) || (dst_addr[2:0] != 3'd0))
          state_nxt = ERR;
        else if (len == '0)
          state_nxt = DONE;
        else
          state_nxt = READ;
      end
      READ: begin
        busy      = 1'b1;
        MemRead   = 1'b1;
        addr      = src_ptr;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        MemWrite  = 1'b1;
        addr      = dst_ptr;
        w_data    = data_buf;
        state_nxt = (remaining == LEN_W'(1)) ? DONE : READ;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        busy      = 1'b1;
        error     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine with a 128-doubleword memory model whose
// word i initially holds i (byte address k holds k/8).
module tb_dmem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, error, MemRead, MemWrite;
  logic [63:0] addr, w_data, r_data;

  int checks = 0;
  int errors = 0;
  int rd_cnt, wr_cnt, done_cnt, viol;

  logic [63:0] mem [0:127];

  always #5 clk = ~clk;

  dmem_copy_engine #(.LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .error(error),
    .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .w_data(w_data),
    .r_data(r_data)
  );

  assign r_data = MemRead ? mem[addr[9:3]] : 64'd0;

  always @(posedge clk) if (MemWrite) mem[addr[9:3]] <= w_data;

  // Bus activity counters and protocol-rule violations, sampled mid-cycle.
  always @(negedge clk) if (rst_n) begin
    if (MemRead) rd_cnt++;
    if (MemWrite) wr_cnt++;
    if (done) done_cnt++;
    if (MemRead && MemWrite) viol++;
    if (!MemWrite && w_data != 64'd0) viol++;
    if (!MemRead && !MemWrite && addr != 64'd0) viol++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 128; i++) mem[i] = 64'(i);
  endtask

  task automatic clr_cnt();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Returns positioned in cycle 1 after the start edge E0.
  task automatic kick(input logic [63:0] s, input logic [63:0] d, input logic [15:0] l);
    @(posedge clk); #1;
    clr_cnt();
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    viol = 0;
    clr_cnt();
    init_mem();
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
    check("rst_addr", addr, 64'd0);
    check("rst_wdata", w_data, 64'd0);
    rst_n = 1'b1;

    // basic copy 64 -> 512, len 2
    kick(64'd64, 64'd512, 16'd2);
    check("c1_read", {62'd0, MemRead, MemWrite}, 64'd2);
    check("c1_addr", addr, 64'd64);
    check("c1_busy", {63'd0, busy}, 64'd1);
    step();
    check("c2_write", {62'd0, MemRead, MemWrite}, 64'd1);
    check("c2_addr", addr, 64'd512);
    check("c2_wdata", w_data, 64'd8);
    step();
    check("c3_addr", addr, 64'd72);
    step();
    check("c4_addr", addr, 64'd520);
    check("c4_wdata", w_data, 64'd9);
    step();
    check("c5_done", {62'd0, done, busy}, 64'd3);
    step();
    check("c6_idle", {62'd0, done, busy}, 64'd0);
    check("copy_m512", mem[64], 64'd8);
    check("copy_m520", mem[65], 64'd9);
    check("copy_counts", {rd_cnt[31:0], wr_cnt[31:0]}, {32'd2, 32'd2});

    // len = 0
    init_mem();
    kick(64'd64, 64'd512, 16'd0);
    check("len0_done", {62'd0, done, busy}, 64'd3);
    step();
    check("len0_idle", {63'd0, busy}, 64'd0);
    check("len0_strobes", {rd_cnt[31:0], wr_cnt[31:0]}, 64'd0);
    check("len0_mem", mem[64], 64'd64);

    // misaligned source
    kick(64'd68, 64'd512, 16'd4);
    check("mis_err", {61'd0, error, done, busy}, 64'd5);
    step();
    check("mis_idle", {61'd0, error, done, busy}, 64'd0);
    step(); step();
    check("mis_strobes", {rd_cnt[31:0], wr_cnt[31:0]}, 64'd0);
    check("mis_mem", mem[64], 64'd64);

    // overlap, dst = src + 8
    init_mem();
    kick(64'd64, 64'd72, 16'd3);
    for (int i = 0; i < 6; i++) step();
    check("ovl_done", {63'd0, done}, 64'd1);
    check("ovl_m72", mem[9], 64'd8);
    check("ovl_m80", mem[10], 64'd8);
    check("ovl_m88", mem[11], 64'd8);

    // start re-pulsed while busy
    init_mem();
    kick(64'd64, 64'd512, 16'd4);
    step();
    src_addr = 64'd128; dst_addr = 64'd768; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("busy_c9_done", {62'd0, done, busy}, 64'd3);
    step();
    check("busy_c10_idle", {63'd0, busy}, 64'd0);
    step(); step(); step();
    check("busy_counts", {rd_cnt[31:0], wr_cnt[31:0]}, {32'd4, 32'd4});
    check("busy_done_cnt", 64'(done_cnt), 64'd1);
    check("busy_m536", mem[67], 64'd11);
    check("busy_m768", mem[96], 64'd96);

    // reset during second READ
    init_mem();
    kick(64'd64, 64'd512, 16'd4);
    step(); step();
    check("rst_mid_read", {62'd0, MemRead, MemWrite}, 64'd2);
    check("rst_mid_addr", addr, 64'd72);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_flags", {59'd0, busy, done, error, MemRead, MemWrite}, 64'd0);
    check("rst_async_addr", addr, 64'd0);
    check("rst_async_wdata", w_data, 64'd0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check("rst_counts", {rd_cnt[31:0], wr_cnt[31:0]}, {32'd1, 32'd1});
    check("rst_m512", mem[64], 64'd8);
    check("rst_m520", mem[65], 64'd65);
    kick(64'd80, 64'd600, 16'd1);
    check("post_read_addr", addr, 64'd80);
    step();
    check("post_wdata", w_data, 64'd10);
    step();
    check("post_done", {63'd0, done}, 64'd1);
    step();
    check("post_m600", mem[75], 64'd10);
    check("protocol_viol", 64'(viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_copy_engine.md
# dmem_copy_engine

Bus-master block-copy engine for the LEGv8 data memory. On a start pulse it moves a run of 64-bit doublewords from a source byte address to a destination byte address by driving the data memory's MemRead/MemWrite/addr/w_data port and consuming r_data. It sits beside the datapath as a second master of data_mem, muxed in by the top level while busy, for bulk initialisation and copy of data-memory regions during tests and bring-up.

## Interface
- LEN_W, 16, width of the doubleword count
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- src_addr  in  `WORD  source byte address; must be 8-byte aligned
- dst_addr  in  `WORD  destination byte address; must be 8-byte aligned
- len  in  LEN_W  number of doublewords to copy
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle pulse at normal completion
- error  out  1  one-cycle pulse when a request is rejected
- MemRead  out  1  read strobe to data_mem
- MemWrite  out  1  write strobe to data_mem
- addr  out  `WORD  byte address to data_mem
- w_data  out  `WORD  write data to data_mem
- r_data  in  `WORD  read data from data_mem, valid in the same cycle as MemRead

## Operation
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE: all outputs 0. On start: src_addr, dst_addr and len are latched into src_ptr, dst_ptr and remaining.
  - If src_addr[2:0] or dst_addr[2:0] is nonzero, go to ERR.
  - Otherwise, if len == 0, go to DONE.
  - Otherwise, go to READ.
- READ: MemRead=1, MemWrite=0, addr=src_ptr. At the clock edge, r_data is captured into data_buf, src_ptr += 8, and the state goes to WRITE.
- WRITE: MemWrite=1, MemRead=0, addr=dst_ptr, w_data=data_buf. At the edge, dst_ptr += 8 and remaining -= 1. If remaining was 1, go to DONE; otherwise go to READ.
- DONE: done=1, busy=1, then IDLE.
- ERR: error=1, busy=1, no memory strobes, then IDLE.
- The copy always runs in ascending address order. For an overlapping region with dst > src, the result is the defined ascending-order result; there is no overlap detection.
- Pointers are `WORD-bit and wrap modulo 2^64. No range check is made against the data_mem SIZE.
- start outside IDLE is ignored. It is neither queued nor reported as an error.
- MemRead and MemWrite are never high in the same cycle.
- w_data is 0 whenever MemWrite=0. addr is 0 in IDLE, DONE and ERR.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, and busy, done, error, MemRead, MemWrite, addr and w_data are all 0. Internal pointers, remaining and data_buf are cleared.
- Reset asserted mid-copy aborts immediately. Strobes drop asynchronously. A write already committed by data_mem stays; no further accesses occur.
- Take start high in the cycle ending at edge E0:
  - the first READ is the cycle after E0;
  - each doubleword takes 2 cycles (READ then WRITE);
  - for len=N≥1, done is high in cycle 2N+1 after E0, and busy is high in cycles 1..2N+1.
- len=0: done in cycle 1 after E0, with no strobes.
- Misaligned request: error in cycle 1 after E0, with no strobes.
- A new start is accepted in the cycle immediately after the done or error cycle.
- Outputs are registered state decodes. addr and w_data are stable for the full strobe cycle, so data_mem's posedge write samples them cleanly.

## Test plan
- Data file sets mem[k] = k/8 (so addr 64 holds 8, addr 128 holds 16). Stimulus: src=64, dst=512, len=2. Required: read strobes at 64 then 72; writes 8→512 and 9→520; done in cycle 5; memory at 512/520 reads back 8/9.
- len=0, src=64, dst=512: done in cycle 1; MemRead and MemWrite stay 0; memory unchanged.
- src=68 (misaligned), dst=512, len=4: error pulse in cycle 1; no strobes; memory at 512 unchanged.
- Overlap: src=64, dst=72, len=3. Required: 72, 80 and 88 all end up holding 8 (ascending propagation).
- start re-pulsed during busy of a len=4 copy: it is ignored. Exactly 4 reads and 4 writes occur; a single done in cycle 9.
- rst_n pulsed low during the second READ of a len=4 copy from src=64 to dst=512:
  - all outputs go to 0 asynchronously;
  - 512 holds 8 and 520 is unchanged;
  - after release, a new start with len=1 completes normally.
